// File: rtl/btn_ctrl_pkg.sv
// btn_ctrl_pkg: shared button FSM encoding, default debounce length and index wrap helper
package btn_ctrl_pkg;
    typedef enum logic [1:0] {ST_SCAN, ST_WAIT, ST_COMMIT} state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 100000;
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return (i + 1 >= n) ? 0 : i + 1;
    endfunction
endpackage

// File: rtl/button_scan_controller_if.sv
// button_scan_controller_if: button levels/pulses bundle; event port exists only with BTN_EVENT_FIFO_EN
interface button_scan_controller_if #(parameter int N_BTN = 4);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] out;
    logic [N_BTN-1:0] press_pulse;
    logic [N_BTN-1:0] release_pulse;
    logic             busy;
`ifdef BTN_EVENT_FIFO_EN
    localparam int IDX_W = $clog2(N_BTN);
    logic             evt_valid;
    logic [IDX_W-1:0] evt_idx;
    logic             evt_press;
    logic             evt_ready;
    modport master (output btn, evt_ready, input out, press_pulse, release_pulse, busy, evt_valid, evt_idx, evt_press);
    modport slave (input btn, evt_ready, output out, press_pulse, release_pulse, busy, evt_valid, evt_idx, evt_press);
`else
    modport master (output btn, input out, press_pulse, release_pulse, busy);
    modport slave (input btn, output out, press_pulse, release_pulse, busy);
`endif
endinterface

// File: rtl/debounce_timer.sv
// debounce_timer: single shared settle counter, saturates at DEBOUNCE_CYCLES-1 and flags done there
module debounce_timer import btn_ctrl_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic done
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    assign done = cnt_q == LAST;
    // restart on clear, otherwise count up and hold at the last value
    always_comb cnt_d = clear ? '0 : (en && !done) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/button_scan_controller.sv
// button_scan_controller: round-robin debouncer sharing one timer; BTN_EVENT_FIFO_EN adds a one-entry event slot
module button_scan_controller import btn_ctrl_pkg::*; #(
    parameter int N_BTN = 4,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input logic clk,
    input logic rst,
    button_scan_controller_if.slave bus
);
    localparam int IDX_W = $clog2(N_BTN);
    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
    logic [N_BTN-1:0] meta_q, meta_d, sync_q, sync_d, out_q, out_d, press, rel;
    logic             clear, en, done, fire;
    function automatic logic [IDX_W-1:0] nxt(input logic [IDX_W-1:0] i);
        return IDX_W'(wrap_inc(32'(i), N_BTN));
    endfunction
    debounce_timer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_timer (
        .clk(clk), .rst(rst), .clear(clear), .en(en), .done(done)
    );
    assign bus.out = out_q;
    assign bus.press_pulse = press;
    assign bus.release_pulse = rel;
    assign bus.busy = state_q != ST_SCAN;
`ifdef BTN_EVENT_FIFO_EN
    logic             evt_valid_q, evt_valid_d, evt_press_q, evt_press_d;
    logic [IDX_W-1:0] evt_idx_q, evt_idx_d;
    assign fire = !(evt_valid_q && !bus.evt_ready);
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_idx = evt_idx_q;
    assign bus.evt_press = evt_press_q;
    // event slot drains on handshake and reloads on every committed edge
    always_comb begin
        evt_valid_d = evt_valid_q && !bus.evt_ready;
        evt_idx_d = evt_idx_q;
        evt_press_d = evt_press_q;
        if (state_q == ST_COMMIT && fire) begin
            evt_valid_d = 1'b1;
            evt_idx_d = idx_q;
            evt_press_d = !out_q[idx_q];
        end
    end
    // event slot registers
    always_ff @(posedge clk) begin
        evt_valid_q <= rst ? 1'b0 : evt_valid_d;
        evt_idx_q <= rst ? '0 : evt_idx_d;
        evt_press_q <= rst ? 1'b0 : evt_press_d;
    end
`else
    assign fire = 1'b1;
`endif
    // two-flop synchroniser inputs
    always_comb begin
        meta_d = bus.btn;
        sync_d = meta_q;
    end
    // scan for a disagreeing button, time its stability, then commit the new level
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        idx_d = idx_q;
        out_d = out_q;
        clear = 1'b0;
        en = 1'b0;
        press = '0;
        rel = '0;
        case (state_q)
            ST_SCAN:
                if (sync_q[ptr_q] != out_q[ptr_q]) begin
                    idx_d = ptr_q;
                    clear = 1'b1;
                    state_d = ST_WAIT;
                end else ptr_d = nxt(ptr_q);
            ST_WAIT:
                if (sync_q[idx_q] == out_q[idx_q]) begin
                    ptr_d = nxt(idx_q);
                    state_d = ST_SCAN;
                end else if (done) state_d = ST_COMMIT;
                else en = 1'b1;
            ST_COMMIT:
                if (fire) begin
                    out_d[idx_q] = !out_q[idx_q];
                    press[idx_q] = !out_q[idx_q];
                    rel[idx_q] = out_q[idx_q];
                    ptr_d = nxt(idx_q);
                    state_d = ST_SCAN;
                end
            default: state_d = ST_SCAN;
        endcase
    end
    // state, pointer, level and synchroniser registers
    always_ff @(posedge clk) begin
        state_q <= rst ? ST_SCAN : state_d;
        ptr_q <= rst ? '0 : ptr_d;
        idx_q <= rst ? '0 : idx_d;
        out_q <= rst ? '0 : out_d;
        meta_q <= rst ? '0 : meta_d;
        sync_q <= rst ? '0 : sync_d;
    end
endmodule

// File: tb/tb_button_scan_controller.sv
// tb_button_scan_controller: directed scenarios plus random stimulus checked against a behavioural model
module tb_button_scan_controller;
    localparam int N = 4;
    localparam int D = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    button_scan_controller_if #(.N_BTN(N)) bif();
    button_scan_controller #(.N_BTN(N), .DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .bus(bif));
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit started = 0;
    logic [N-1:0] m_s1, m_s2, m_out;
    int m_ptr, m_idx, m_phase, m_left;
    logic m_ev_valid = 1'b0;
    logic m_ev_press = 1'b0;
    int m_ev_idx = 0;
    int press_cnt[N];
    int rel_cnt[N];
    int press_at[N];
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask
    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d cycle=%0d", name, act, lo, hi, cyc);
        end
    endtask
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask
    task automatic clear_counts();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i] = 0;
            press_at[i] = -1;
        end
    endtask
    function automatic int total_pulses();
        int s = 0;
        for (int i = 0; i < N; i++) s += press_cnt[i] + rel_cnt[i];
        return s;
    endfunction
    function automatic bit m_stall();
`ifdef BTN_EVENT_FIFO_EN
        return m_ev_valid && !bif.evt_ready;
`else
        return 1'b0;
`endif
    endfunction
    // model: a button that disagrees when its turn comes must stay disagreeing D cycles, then flips
    initial forever begin
        @(posedge clk);
        started = 1;
        cyc++;
        if (rst) begin
            m_s1 = '0;
            m_s2 = '0;
            m_out = '0;
            m_ptr = 0;
            m_idx = 0;
            m_phase = 0;
            m_left = 0;
            m_ev_valid = 1'b0;
        end else begin
            bit stall;
            stall = m_stall();
`ifdef BTN_EVENT_FIFO_EN
            if (m_ev_valid && bif.evt_ready) m_ev_valid = 1'b0;
`endif
            if (m_phase == 0) begin
                if (m_s2[m_ptr] != m_out[m_ptr]) begin
                    m_idx = m_ptr;
                    m_left = D;
                    m_phase = 1;
                end else m_ptr = (m_ptr + 1) % N;
            end else if (m_phase == 1) begin
                if (m_s2[m_idx] == m_out[m_idx]) begin
                    m_ptr = (m_idx + 1) % N;
                    m_phase = 0;
                end else begin
                    m_left--;
                    if (m_left == 0) m_phase = 2;
                end
            end else if (!stall) begin
                m_ev_valid = 1'b1;
                m_ev_idx = m_idx;
                m_ev_press = !m_out[m_idx];
                m_out[m_idx] = !m_out[m_idx];
                m_ptr = (m_idx + 1) % N;
                m_phase = 0;
            end
            m_s2 = m_s1;
            m_s1 = bif.btn;
        end
    end
    // compare DUT against the model every cycle, away from the clock edge
    initial forever begin
        @(negedge clk);
        if (started) begin
            logic [N-1:0] ep, er;
            ep = '0;
            er = '0;
            if (m_phase == 2 && !m_stall()) begin
                ep[m_idx] = !m_out[m_idx];
                er[m_idx] = m_out[m_idx];
            end
            chk("out", int'(bif.out), int'(m_out));
            chk("busy", int'(bif.busy), int'(m_phase != 0));
            chk("press_pulse", int'(bif.press_pulse), int'(ep));
            chk("release_pulse", int'(bif.release_pulse), int'(er));
            chk("single_pulse", int'($countones({bif.press_pulse, bif.release_pulse}) <= 1), 1);
`ifdef BTN_EVENT_FIFO_EN
            chk("evt_valid", int'(bif.evt_valid), int'(m_ev_valid));
            if (m_ev_valid) begin
                chk("evt_idx", int'(bif.evt_idx), m_ev_idx);
                chk("evt_press", int'(bif.evt_press), int'(m_ev_press));
            end
`endif
            for (int i = 0; i < N; i++) begin
                if (bif.press_pulse[i]) begin
                    press_cnt[i]++;
                    press_at[i] = cyc;
                end
                if (bif.release_pulse[i]) rel_cnt[i]++;
            end
        end
    end
    initial begin
        int t0, lat, gap;
        bit seen;
        clear_counts();
        bif.btn = '0;
`ifdef BTN_EVENT_FIFO_EN
        bif.evt_ready = 1'b1;
`endif
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out", int'(bif.out), 0);
        chk("reset_busy", int'(bif.busy), 0);
        @(posedge clk);
        #2;
        clear_counts();
        t0 = cyc;
        lat = -1;
        bif.btn = 4'b0001;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (lat < 0 && bif.out[0]) lat = cyc - t0;
            @(posedge clk);
            #2;
        end
        chk_rng("clean_latency", lat, 12, 15);
        chk("clean_press_cnt", press_cnt[0], 1);
        chk("clean_other_pulses", total_pulses() - press_cnt[0], 0);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bif.btn[1] = !bif.btn[1];
            tick(3);
        end
        bif.btn[1] = 1'b0;
        tick(20);
        chk("bounce_out", int'(bif.out[1]), 0);
        chk("bounce_pulses", press_cnt[1] + rel_cnt[1], 0);
        clear_counts();
        bif.btn = 4'b1101;
        tick(45);
        chk("simul_out", int'(bif.out[3:2]), 3);
        chk("simul_press2", press_cnt[2], 1);
        chk("simul_press3", press_cnt[3], 1);
        gap = press_at[3] - press_at[2];
        if (gap < 0) gap = -gap;
        chk_rng("simul_gap", gap, 9, 100);
        clear_counts();
        bif.btn[0] = 1'b0;
        tick(25);
        chk("release_cnt", rel_cnt[0], 1);
        chk("release_out", int'(bif.out[0]), 0);
        bif.btn[1] = 1'b1;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bif.busy;
        end
        chk("wait_busy_seen", int'(seen), 1);
        @(posedge clk);
        #2;
        tick(2);
        clear_counts();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_busy", int'(bif.busy), 0);
        chk("midwait_out", int'(bif.out), 0);
        chk("midwait_pulses", total_pulses(), 0);
        @(posedge clk);
        #2;
        bif.btn = '0;
        tick(20);
`ifdef BTN_EVENT_FIFO_EN
        bif.evt_ready = 1'b0;
        bif.btn[2] = 1'b1;
        tick(25);
        @(negedge clk);
        chk("fifo_valid", int'(bif.evt_valid), 1);
        chk("fifo_idx2", int'(bif.evt_idx), 2);
        chk("fifo_press", int'(bif.evt_press), 1);
        @(posedge clk);
        #2;
        bif.btn[3] = 1'b1;
        tick(25);
        @(negedge clk);
        chk("fifo_stall_busy", int'(bif.busy), 1);
        chk("fifo_stall_out3", int'(bif.out[3]), 0);
        chk("fifo_hold_idx", int'(bif.evt_idx), 2);
        @(posedge clk);
        #2;
        bif.evt_ready = 1'b1;
        tick(1);
        bif.evt_ready = 1'b0;
        @(negedge clk);
        chk("fifo_next_valid", int'(bif.evt_valid), 1);
        chk("fifo_next_idx", int'(bif.evt_idx), 3);
        chk("fifo_out3", int'(bif.out[3]), 1);
        @(posedge clk);
        #2;
        bif.evt_ready = 1'b1;
        bif.btn = '0;
        tick(60);
`endif
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) bif.btn[$urandom_range(N - 1)] ^= 1'b1;
`ifdef BTN_EVENT_FIFO_EN
            bif.evt_ready = $urandom_range(3) != 0;
`endif
            if ($urandom_range(999) == 0) rst = 1'b1;
            tick(1);
            rst = 1'b0;
        end
        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
